fetch_stage: RTL and testbench
==============================

Name: fetch_stage

Overview:
- Instruction-fetch stage sitting directly downstream of the PC register.
- Consumes the current PC and drives the address of a synchronous instruction memory (one-cycle read latency).
- Computes the next PC and feeds it back to the PC register input.
- Delivers instruction + PC to decode through a registered IF/ID boundary with stall, redirect and a one-entry skid buffer.

Parameters:
- PC_WIDTH, 6, width of PC (word index into instruction memory).
- INSTR_WIDTH, 32, instruction word width.
- RESET_PC, 0, next-PC value driven while in reset.

Ports:
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  synchronous reset, active-high.
- pc  in  PC_WIDTH  current PC from PC register output.
- pc_next  out  PC_WIDTH  next PC, to PC register input (combinational).
- imem_addr  out  PC_WIDTH  instruction memory read address (combinational, = pc).
- imem_data  in  INSTR_WIDTH  memory read data for address presented previous cycle.
- stall  in  1  decode cannot accept; hold IF/ID and PC.
- branch_taken  in  1  redirect to branch_target.
- branch_target  in  PC_WIDTH  branch destination.
- jump  in  1  redirect to jump_target.
- jump_target  in  PC_WIDTH  jump destination.
- valid_out  out  1  IF/ID holds a real instruction.
- instr_out  out  INSTR_WIDTH  IF/ID instruction; 0 (NOP) whenever valid_out=0.
- pc_out  out  PC_WIDTH  PC of instr_out.
- pc_plus1_out  out  PC_WIDTH  pc_out+1 mod 2^PC_WIDTH, registered.

Behaviour:
- Priority each cycle: rst > redirect (branch_taken > jump) > stall > normal.
- Internal state:
  - f1_valid, f1_pc: fetch in flight, data arriving this cycle.
  - skid_valid, skid_instr, skid_pc.
  - IF/ID output registers.
- imem_addr = pc always.
- pc_next (combinational), by priority:
  - rst -> RESET_PC
  - branch_taken -> branch_target
  - jump -> jump_target
  - stall -> pc
  - else pc+1 (wraps 2^PC_WIDTH-1 -> 0)
- f1 update: f1_valid <= !rst && !redirect && !stall; f1_pc <= pc.
- Reset (synchronous):
  - f1_valid, skid_valid, valid_out = 0; instr_out, pc_out = 0; pc_plus1_out = 1.
  - First valid_out=1 appears 2 cycles after rst deasserts (issue cycle + data cycle), provided no stall/redirect.
- Redirect (branch_taken or jump):
  - clears f1_valid, skid_valid, valid_out; instr_out <= 0.
  - Target instruction reaches IF/ID 2 cycles later.
  - Redirect overrides a simultaneous stall: the IF/ID contents are discarded.
- Stall, no redirect:
  - IF/ID registers hold.
  - If f1_valid=1, imem_data/f1_pc are captured into skid (skid_valid <= 1).
  - The fetch issued this cycle is discarded (f1_valid <= 0) and reissued after release because PC is held.
- Normal, no stall, no redirect:
  - skid_valid=1 -> IF/ID <= skid, skid_valid <= 0.
  - else f1_valid=1 -> IF/ID <= {imem_data, f1_pc}.
  - else IF/ID <= bubble (valid_out=0, instr_out=0).
- Invariant: skid_valid=1 implies f1_valid=0, so the skid never needs more than one entry. Simultaneous skid and f1 valid is illegal; assert in simulation.
- pc_plus1_out is updated together with pc_out.
- Stall release produces no bubble and no duplicate: the sequence A, A+1, ... is continuous.
- Reset mid-stall or with a full skid discards everything. Reset overrides redirect and stall.

Test Plan:
- Reset then run, imem_data = 0x1000_0000 + address -> valid_out first high 2 cycles after rst low with pc_out=0, instr_out=0x1000_0000; then pc_out 1, 2, 3 consecutively.
- Wrap: run from pc=62 -> pc_next 63 then 0; pc_out sequence 62, 63, 0; pc_plus1_out for 63 = 0.
- Single-cycle stall while pc_out=4 -> pc_next=pc during stall, IF/ID holds 4, skid captures 5; after release IF/ID shows 5 then 6, no gap or repeat.
- Multi-cycle stall (3 cycles) -> IF/ID stays 4, skid holds only 5, pc frozen at 6; release yields 5, 6, 7.
- branch_taken with branch_target=20 together with jump, jump_target=40 -> pc_next=20; valid_out=0 and instr_out=0 for 2 cycles; then pc_out=20.
- Redirect during stall with full skid (jump to 10) -> skid and IF/ID flushed, valid_out=0; pc_out=10 appears 2 cycles later. Also assert rst for one cycle mid-stream -> all valids 0, pc_next=0 that cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: next-PC selection, one-cycle imem latency tracking,
// and a registered IF/ID boundary backed by a one-entry skid buffer.
module fetch_stage #(
  parameter int                  PC_WIDTH    = 6,
  parameter int                  INSTR_WIDTH = 32,
  parameter logic [PC_WIDTH-1:0] RESET_PC    = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [PC_WIDTH-1:0]    pc,
  output logic [PC_WIDTH-1:0]    pc_next,
  output logic [PC_WIDTH-1:0]    imem_addr,
  input  logic [INSTR_WIDTH-1:0] imem_data,
  input  logic                   stall,
  input  logic                   branch_taken,
  input  logic [PC_WIDTH-1:0]    branch_target,
  input  logic                   jump,
  input  logic [PC_WIDTH-1:0]    jump_target,
  output logic                   valid_out,
  output logic [INSTR_WIDTH-1:0] instr_out,
  output logic [PC_WIDTH-1:0]    pc_out,
  output logic [PC_WIDTH-1:0]    pc_plus1_out
);

  logic                   redirect;
  logic                   f1_valid;
  logic [PC_WIDTH-1:0]    f1_pc;
  logic                   skid_valid;
  logic [INSTR_WIDTH-1:0] skid_instr;
  logic [PC_WIDTH-1:0]    skid_pc;

  assign redirect  = branch_taken | jump;
  assign imem_addr = pc;

  always_comb begin
    pc_next = pc + PC_WIDTH'(1);
    if (rst)               pc_next = RESET_PC;
    else if (branch_taken) pc_next = branch_target;
    else if (jump)         pc_next = jump_target;
    else if (stall)        pc_next = pc;
  end

  // f1 tracks the fetch whose data shows up on imem_data next cycle.
  always_ff @(posedge clk) begin
    f1_pc <= pc;
    if (rst) begin
      f1_valid     <= 1'b0;
      skid_valid   <= 1'b0;
      skid_instr   <= '0;
      skid_pc      <= '0;
      valid_out    <= 1'b0;
      instr_out    <= '0;
      pc_out       <= '0;
      pc_plus1_out <= PC_WIDTH'(1);
    end else if (redirect) begin
      f1_valid   <= 1'b0;
      skid_valid <= 1'b0;
      valid_out  <= 1'b0;
      instr_out  <= '0;
    end else if (stall) begin
      // PC is held, so the fetch issued now is dropped and reissued later.
      f1_valid <= 1'b0;
      if (f1_valid) begin
        skid_valid <= 1'b1;
        skid_instr <= imem_data;
        skid_pc    <= f1_pc;
      end
    end else begin
      f1_valid <= 1'b1;
      if (skid_valid) begin
        skid_valid   <= 1'b0;
        valid_out    <= 1'b1;
        instr_out    <= skid_instr;
        pc_out       <= skid_pc;
        pc_plus1_out <= skid_pc + PC_WIDTH'(1);
      end else if (f1_valid) begin
        valid_out    <= 1'b1;
        instr_out    <= imem_data;
        pc_out       <= f1_pc;
        pc_plus1_out <= f1_pc + PC_WIDTH'(1);
      end else begin
        valid_out <= 1'b0;
        instr_out <= '0;
      end
    end
  end

  // A second skid entry would be needed if both were ever valid together.
  assert property (@(posedge clk) disable iff (rst) !(skid_valid && f1_valid));

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written
// corner sequences, then random stimulus against a queue-based delivery model.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [5:0]  pc;
  logic [5:0]  pc_next;
  logic [5:0]  imem_addr;
  logic [31:0] imem_data;
  logic        stall;
  logic        branch_taken;
  logic [5:0]  branch_target;
  logic        jump;
  logic [5:0]  jump_target;
  logic        valid_out;
  logic [31:0] instr_out;
  logic [5:0]  pc_out;
  logic [5:0]  pc_plus1_out;

  logic [31:0] mem [64];
  int          total;
  int          bad;

  typedef struct {
    logic       r;
    logic       s;
    logic       b;
    logic [5:0] bt;
    logic       j;
    logic [5:0] jt;
    logic [5:0] exp_next;
    logic       exp_v;
    logic [5:0] exp_pc;
  } vec_t;

  vec_t tbl [16];

  fetch_stage #(
    .PC_WIDTH(6),
    .INSTR_WIDTH(32),
    .RESET_PC(6'd0)
  ) dut (
    .clk(clk),
    .rst(rst),
    .pc(pc),
    .pc_next(pc_next),
    .imem_addr(imem_addr),
    .imem_data(imem_data),
    .stall(stall),
    .branch_taken(branch_taken),
    .branch_target(branch_target),
    .jump(jump),
    .jump_target(jump_target),
    .valid_out(valid_out),
    .instr_out(instr_out),
    .pc_out(pc_out),
    .pc_plus1_out(pc_plus1_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // PC register and synchronous instruction memory surrounding the stage.
  always @(posedge clk) begin
    pc        <= pc_next;
    imem_data <= mem[imem_addr];
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic r, input logic s, input logic b, input logic [5:0] bt_v,
                               input logic j, input logic [5:0] jt_v);
    rst           = r;
    stall         = s;
    branch_taken  = b;
    branch_target = bt_v;
    jump          = j;
    jump_target   = jt_v;
  endtask

  task automatic checkOutput(input string name, input logic exp_v, input logic [31:0] exp_instr,
                             input logic [5:0] exp_pc, input logic chk_pc);
    logic [5:0] exp_p1;
    exp_p1 = exp_pc + 6'd1;
    check({name, " valid_out"}, 32'(valid_out), 32'(exp_v));
    check({name, " instr_out"}, instr_out, exp_instr);
    if (chk_pc) begin
      check({name, " pc_out"}, 32'(pc_out), 32'(exp_pc));
      check({name, " pc_plus1_out"}, 32'(pc_plus1_out), 32'(exp_p1));
    end
  endtask

  // One directed cycle: drive, check combinational outputs, clock, check IF/ID.
  task automatic step(input string name, input logic r, input logic s, input logic b,
                      input logic [5:0] bt_v, input logic j, input logic [5:0] jt_v,
                      input logic [5:0] exp_next, input logic exp_v, input logic [5:0] exp_pc);
    logic [31:0] exp_instr;
    applyStimulus(r, s, b, bt_v, j, jt_v);
    #1;
    check({name, " pc_next"}, 32'(pc_next), 32'(exp_next));
    check({name, " imem_addr"}, 32'(imem_addr), 32'(pc));
    @(posedge clk);
    #1;
    exp_instr = exp_v ? (32'h1000_0000 + 32'(exp_pc)) : 32'h0;
    checkOutput(name, exp_v, exp_instr, exp_pc, exp_v | r);
  endtask

  function automatic vec_t mk(input logic r, input logic s, input logic b, input logic [5:0] bt_v,
                              input logic j, input logic [5:0] jt_v, input logic [5:0] exp_next,
                              input logic exp_v, input logic [5:0] exp_pc);
    vec_t v;
    v.r = r; v.s = s; v.b = b; v.bt = bt_v; v.j = j; v.jt = jt_v;
    v.exp_next = exp_next; v.exp_v = exp_v; v.exp_pc = exp_pc;
    return v;
  endfunction

  // Reference model state: fetch in flight, arrived-but-undelivered queue, IF/ID view.
  int          issued;
  int          avail [$];
  logic        m_valid;
  logic [5:0]  m_pc;
  logic [31:0] m_instr;
  logic [5:0]  m_pcreg;

  initial begin
    total = 0;
    bad   = 0;
    for (int i = 0; i < 64; i++) mem[i] = 32'h1000_0000 + 32'(i);

    tbl[0]  = mk(1, 0, 0, 0,  0, 0,  6'd0,  0, 6'd0);
    tbl[1]  = mk(1, 0, 0, 0,  0, 0,  6'd0,  0, 6'd0);
    tbl[2]  = mk(0, 0, 0, 0,  0, 0,  6'd1,  0, 6'd0);
    tbl[3]  = mk(0, 0, 0, 0,  0, 0,  6'd2,  1, 6'd0);
    tbl[4]  = mk(0, 0, 0, 0,  0, 0,  6'd3,  1, 6'd1);
    tbl[5]  = mk(0, 0, 0, 0,  0, 0,  6'd4,  1, 6'd2);
    tbl[6]  = mk(0, 0, 0, 0,  0, 0,  6'd5,  1, 6'd3);
    tbl[7]  = mk(0, 0, 0, 0,  0, 0,  6'd6,  1, 6'd4);
    tbl[8]  = mk(0, 1, 0, 0,  0, 0,  6'd6,  1, 6'd4);
    tbl[9]  = mk(0, 0, 0, 0,  0, 0,  6'd7,  1, 6'd5);
    tbl[10] = mk(0, 0, 0, 0,  0, 0,  6'd8,  1, 6'd6);
    tbl[11] = mk(0, 0, 0, 0,  0, 0,  6'd9,  1, 6'd7);
    tbl[12] = mk(0, 0, 1, 20, 1, 40, 6'd20, 0, 6'd0);
    tbl[13] = mk(0, 0, 0, 0,  0, 0,  6'd21, 0, 6'd0);
    tbl[14] = mk(0, 0, 0, 0,  0, 0,  6'd22, 1, 6'd20);
    tbl[15] = mk(0, 0, 0, 0,  0, 0,  6'd23, 1, 6'd21);

    for (int k = 0; k < 16; k++)
      step($sformatf("vec%0d", k), tbl[k].r, tbl[k].s, tbl[k].b, tbl[k].bt,
           tbl[k].j, tbl[k].jt, tbl[k].exp_next, tbl[k].exp_v, tbl[k].exp_pc);

    // Wrap-around at the top of the PC range.
    step("wrap_jump", 0, 0, 0, 0, 1, 62, 6'd62, 0, 6'd0);
    step("wrap_a",    0, 0, 0, 0, 0, 0,  6'd63, 0, 6'd0);
    step("wrap_b",    0, 0, 0, 0, 0, 0,  6'd0,  1, 6'd62);
    step("wrap_c",    0, 0, 0, 0, 0, 0,  6'd1,  1, 6'd63);
    step("wrap_d",    0, 0, 0, 0, 0, 0,  6'd2,  1, 6'd0);

    // Three-cycle stall holding pc_out=4 with 5 parked in the skid.
    step("ms_jump",  0, 0, 0, 0, 1, 2, 6'd2, 0, 6'd0);
    step("ms_run0",  0, 0, 0, 0, 0, 0, 6'd3, 0, 6'd0);
    step("ms_run1",  0, 0, 0, 0, 0, 0, 6'd4, 1, 6'd2);
    step("ms_run2",  0, 0, 0, 0, 0, 0, 6'd5, 1, 6'd3);
    step("ms_run3",  0, 0, 0, 0, 0, 0, 6'd6, 1, 6'd4);
    step("ms_stl0",  0, 1, 0, 0, 0, 0, 6'd6, 1, 6'd4);
    step("ms_stl1",  0, 1, 0, 0, 0, 0, 6'd6, 1, 6'd4);
    step("ms_stl2",  0, 1, 0, 0, 0, 0, 6'd6, 1, 6'd4);
    step("ms_rel0",  0, 0, 0, 0, 0, 0, 6'd7, 1, 6'd5);
    step("ms_rel1",  0, 0, 0, 0, 0, 0, 6'd8, 1, 6'd6);
    step("ms_rel2",  0, 0, 0, 0, 0, 0, 6'd9, 1, 6'd7);

    // Jump while stalled with a full skid flushes both skid and IF/ID.
    step("rs_stall", 0, 1, 0, 0, 0, 0,  6'd9,  1, 6'd7);
    step("rs_jump",  0, 1, 0, 0, 1, 10, 6'd10, 0, 6'd0);
    step("rs_run0",  0, 0, 0, 0, 0, 0,  6'd11, 0, 6'd0);
    step("rs_run1",  0, 0, 0, 0, 0, 0,  6'd12, 1, 6'd10);
    step("rs_run2",  0, 0, 0, 0, 0, 0,  6'd13, 1, 6'd11);

    // Reset mid-stall with a full skid, also overriding a branch.
    step("mr_stall", 0, 1, 0, 0,  0, 0, 6'd13, 1, 6'd11);
    step("mr_rst",   1, 1, 1, 30, 0, 0, 6'd0,  0, 6'd0);
    step("mr_run0",  0, 0, 0, 0,  0, 0, 6'd1,  0, 6'd0);
    step("mr_run1",  0, 0, 0, 0,  0, 0, 6'd2,  1, 6'd0);

    // Random phase with random memory contents.
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    issued  = -1;
    m_valid = 1'b0;
    m_pc    = '0;
    m_instr = '0;
    m_pcreg = '0;
    for (int i = 0; i < 400; i++) begin
      logic       r, s, b, j;
      logic [5:0] bt_v, jt_v, exp_next;
      r    = (i == 0) || ($urandom_range(0, 49) == 0);
      s    = ($urandom_range(0, 99) < 30);
      b    = ($urandom_range(0, 99) < 8);
      j    = ($urandom_range(0, 99) < 8);
      bt_v = 6'($urandom_range(0, 63));
      jt_v = 6'($urandom_range(0, 63));
      if (r)      exp_next = 6'd0;
      else if (b) exp_next = bt_v;
      else if (j) exp_next = jt_v;
      else if (s) exp_next = m_pcreg;
      else        exp_next = m_pcreg + 6'd1;

      applyStimulus(r, s, b, bt_v, j, jt_v);
      #1;
      check("rand pc_next", 32'(pc_next), 32'(exp_next));
      if (i != 0) check("rand imem_addr", 32'(imem_addr), 32'(m_pcreg));

      if (r) begin
        issued = -1;
        avail.delete();
        m_valid = 1'b0;
        m_pc    = '0;
        m_instr = '0;
      end else if (b || j) begin
        issued = -1;
        avail.delete();
        m_valid = 1'b0;
        m_instr = '0;
      end else begin
        if (issued >= 0) avail.push_back(issued);
        issued = -1;
        if (!s) begin
          issued = int'(m_pcreg);
          if (avail.size() > 0) begin
            int p;
            p       = avail.pop_front();
            m_valid = 1'b1;
            m_pc    = 6'(p);
            m_instr = mem[p];
          end else begin
            m_valid = 1'b0;
            m_instr = '0;
          end
        end
      end
      m_pcreg = exp_next;

      @(posedge clk);
      #1;
      checkOutput("rand", m_valid, m_instr, m_pc, m_valid | r);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
